// File: rtl/pc_stack_top_pkg.sv
// pc_stack_top_pkg: shared op encodings, legal parameter ranges and strobe decode for the PC.
package pc_stack_top_pkg;
  typedef enum logic [2:0] {OP_HOLD, OP_INC, OP_JMP, OP_JREL, OP_CALL, OP_RET} op_e;
  localparam int ADDR_W_MIN = 4;
  localparam int ADDR_W_MAX = 16;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;
  function automatic bit cfg_ok(input int aw, input int depth);
    return aw >= ADDR_W_MIN && aw <= ADDR_W_MAX && depth >= DEPTH_MIN && depth <= DEPTH_MAX;
  endfunction
  // Bus-loading strobes collapse to hold while the PC itself owns the bus.
  function automatic op_e op_sel(input logic ret, input logic call, input logic j, input logic rel, input logic ce, input logic co_n, input bit rel_en);
    return ret ? OP_RET : call ? (co_n ? OP_CALL : OP_HOLD) : j ? (!co_n ? OP_HOLD : (rel && rel_en) ? OP_JREL : OP_JMP) : ce ? OP_INC : OP_HOLD;
  endfunction
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: LIFO of return addresses; push/pop are ignored when full/empty.
module pc_return_stack #(
  parameter int ADDR_W = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0] sp, sp_m1;
  logic push_ok, pop_ok;
  assign full = sp == SP_W'(STACK_DEPTH);
  assign empty = sp == '0;
  assign sp_m1 = sp - SP_W'(1);
  assign push_ok = push && !full && !pop;
  assign pop_ok = pop && !empty;
  assign dout = mem[IDX_W'(sp_m1)];
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) sp <= '0;
    else sp <= pop_ok ? sp_m1 : push_ok ? sp + SP_W'(1) : sp;
  // Entries are deliberately left out of reset; only sp marks what is valid.
  always_ff @(posedge clk)
    if (push_ok) mem[IDX_W'(sp)] <= din;
endmodule

// File: rtl/pc_stack_top.sv
// pc_stack_top: bus-attached program counter with relative jumps and a call/return stack.
module pc_stack_top import pc_stack_top_pkg::*; #(
  parameter int ADDR_W = 4,
  parameter int STACK_DEPTH = 4,
  parameter int REL_EN = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  inout  wire  [ADDR_W-1:0] bus,
  input  logic              ce,
  input  logic              j,
  input  logic              rel,
  input  logic              call,
  input  logic              ret,
  input  logic              co_n,
  output logic [ADDR_W-1:0] pc_q,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);
  if (!cfg_ok(ADDR_W, STACK_DEPTH)) begin : g_cfg_bad
    $error("pc_stack_top: ADDR_W or STACK_DEPTH out of range");
  end
  op_e op;
  logic [ADDR_W-1:0] pc, pc_d, top;
  logic push, pop, err;
  always_comb begin
    op = op_sel(ret, call, j, rel, ce, co_n, REL_EN != 0);
    push = op == OP_CALL;
    pop = op == OP_RET;
    pc_d = op == OP_RET ? (stk_empty ? pc : top) :
           op == OP_CALL ? (stk_full ? pc : bus) :
           op == OP_JMP ? bus :
           op == OP_JREL ? pc + bus :
           op == OP_INC ? pc + ADDR_W'(1) : pc;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      pc <= '0;
      err <= 1'b0;
    end else begin
      pc <= pc_d;
      err <= err | (pop & stk_empty) | (push & stk_full);
    end
  pc_return_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .clr_n(clr_n), .push(push), .pop(pop), .din(pc),
    .dout(top), .full(stk_full), .empty(stk_empty)
  );
  assign bus = co_n ? 'z : pc;
  assign pc_q = pc;
  assign stk_err = err;
endmodule

// File: tb/tb_pc_stack_top.sv
// tb_pc_stack_top: directed checks of counting, jumps, call/return, errors, contention and async reset.
module tb_pc_stack_top;
  logic clk = 1'b0, clr_n = 1'b0, ce = 1'b0, j = 1'b0, rel = 1'b0, call = 1'b0, ret = 1'b0, co_n = 1'b1;
  logic bus_oe = 1'b0;
  logic [3:0] bus_drv = '0;
  wire [3:0] bus;
  logic [3:0] pc_q;
  logic stk_full, stk_empty, stk_err;
  int n_chk = 0, n_fail = 0;
  assign bus = bus_oe ? bus_drv : 'z;
  always #5 clk = ~clk;
  pc_stack_top #(.ADDR_W(4), .STACK_DEPTH(2), .REL_EN(1)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus), .ce(ce), .j(j), .rel(rel), .call(call), .ret(ret),
    .co_n(co_n), .pc_q(pc_q), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] v);
    bus_oe = 1'b1;
    bus_drv = v;
  endtask
  task automatic idle();
    {ce, j, rel, call, ret} = '0;
    bus_oe = 1'b0;
    co_n = 1'b1;
  endtask
  initial begin
    cyc(); cyc();
    chk("rst_pc", 8'(pc_q), 8'h0);
    chk("rst_empty", 8'(stk_empty), 8'h1);
    chk("rst_full", 8'(stk_full), 8'h0);
    chk("rst_err", 8'(stk_err), 8'h0);
    clr_n = 1'b1;
    ce = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      chk($sformatf("count_%0d", i), 8'(pc_q), 8'(i % 16));
    end
    idle();
    co_n = 1'b0;
    #1 chk("bus_drive", 8'(bus), 8'h1);
    co_n = 1'b1;
    drive(4'h9);
    #1 chk("bus_release", 8'(bus), 8'h9);
    drive(4'h5); j = 1'b1;
    cyc(); chk("jmp_5", 8'(pc_q), 8'h5);
    drive(4'hA);
    cyc(); chk("jmp_abs", 8'(pc_q), 8'hA);
    drive(4'hE); rel = 1'b1;
    cyc(); chk("jmp_rel_neg", 8'(pc_q), 8'h8);
    drive(4'h7);
    cyc(); chk("jmp_rel_wrap", 8'(pc_q), 8'hF);
    drive(4'h3); rel = 1'b0; ce = 1'b1;
    cyc(); chk("jmp_over_ce", 8'(pc_q), 8'h3);
    idle();
    co_n = 1'b0; j = 1'b1; rel = 1'b1;
    cyc(); chk("cont_jrel_pc", 8'(pc_q), 8'h3);
    chk("cont_jrel_err", 8'(stk_err), 8'h0);
    j = 1'b0; rel = 1'b0; call = 1'b1;
    cyc(); chk("cont_call_pc", 8'(pc_q), 8'h3);
    chk("cont_call_empty", 8'(stk_empty), 8'h1);
    idle();
    drive(4'h2); j = 1'b1;
    cyc(); chk("pc_2", 8'(pc_q), 8'h2);
    j = 1'b0; call = 1'b1; drive(4'h8);
    cyc(); chk("call1_pc", 8'(pc_q), 8'h8);
    chk("call1_empty", 8'(stk_empty), 8'h0);
    chk("call1_full", 8'(stk_full), 8'h0);
    drive(4'hC);
    cyc(); chk("call2_pc", 8'(pc_q), 8'hC);
    chk("call2_full", 8'(stk_full), 8'h1);
    drive(4'h5); ret = 1'b1;
    cyc(); chk("retcall_pc", 8'(pc_q), 8'h8);
    chk("retcall_full", 8'(stk_full), 8'h0);
    chk("retcall_empty", 8'(stk_empty), 8'h0);
    idle(); ret = 1'b1;
    cyc(); chk("ret2_pc", 8'(pc_q), 8'h2);
    chk("ret2_empty", 8'(stk_empty), 8'h1);
    chk("nest_err", 8'(stk_err), 8'h0);
    idle(); call = 1'b1; drive(4'h8);
    cyc(); drive(4'hC);
    cyc(); chk("refill_full", 8'(stk_full), 8'h1);
    drive(4'h1);
    cyc(); chk("ovf_pc", 8'(pc_q), 8'hC);
    chk("ovf_err", 8'(stk_err), 8'h1);
    chk("ovf_full", 8'(stk_full), 8'h1);
    idle();
    #1 clr_n = 1'b0;
    #2 chk("async_pc", 8'(pc_q), 8'h0);
    chk("async_empty", 8'(stk_empty), 8'h1);
    chk("async_err", 8'(stk_err), 8'h0);
    cyc(); clr_n = 1'b1; ret = 1'b1;
    cyc(); chk("udf_pc", 8'(pc_q), 8'h0);
    chk("udf_err", 8'(stk_err), 8'h1);
    chk("udf_empty", 8'(stk_empty), 8'h1);
    idle(); ce = 1'b1;
    cyc(); chk("sticky_pc", 8'(pc_q), 8'h1);
    chk("sticky_err", 8'(stk_err), 8'h1);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_stack_top.md
Name: pc_stack_top

Overview:
Parametrised program counter for the 8-bit CPU, the successor to the 4-bit PC. Adds configurable address width, relative jumps and a hardware call/return stack. Shares the tri-state system bus with the other bus agents. The control unit drives it through the ce/j/co_n strobes plus the new call/ret/rel strobes.

Parameters:
ADDR_W, 4, PC and bus width in bits (legal 4..16)
STACK_DEPTH, 4, return-stack entries (legal 1..16, any integer)
REL_EN, 1, 1 enables relative-jump decoding; 0 makes rel ignored

Ports:
clk  input  1  system clock, rising-edge
clr_n  input  1  asynchronous active-low reset
bus  inout  ADDR_W  shared system bus; driven only when co_n=0, else high-Z
ce  input  1  count enable, PC+1
j  input  1  jump: load absolute target from bus
rel  input  1  with j: target = PC + signed(bus) instead of bus
call  input  1  push PC, then load target from bus
ret  input  1  pop stack into PC
co_n  input  1  active-low PC output enable onto bus
pc_q  output  ADDR_W  current PC, always visible (debug/LEDs)
stk_full  output  1  stack holds STACK_DEPTH entries
stk_empty  output  1  stack holds 0 entries
stk_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset: clr_n=0 asynchronously forces pc_q=0, stack pointer=0, stk_empty=1, stk_full=0, stk_err=0. Bus is high-Z whenever co_n=1, including during reset.
- Bus drive is combinational: bus = pc_q when co_n=0, else 'z. There is no cycle latency on output.
- All state updates happen on the rising edge of clk. Next-state priority, highest first:
  1. ret
  2. call
  3. j (rel selects the mode)
  4. ce
  5. hold
- ret:
  - stack not empty -> pc <= top entry; sp decrements.
  - stack empty -> pc unchanged; stk_err <= 1.
- call:
  - stack not full -> stack[sp] <= pc_q, sp increments, pc <= bus.
  - stack full -> no push, pc unchanged; stk_err <= 1.
  - The pushed value is the current pc_q. The control unit has already advanced the PC past the call instruction.
- j with rel=0 -> pc <= bus.
- j with rel=1 and REL_EN=1 -> pc <= pc_q + sign-extended bus. The arithmetic is modulo 2^ADDR_W and no flag is raised.
- j with rel=1 and REL_EN=0 -> treated as an absolute j.
- ce -> pc <= pc_q + 1. Wraps from 2^ADDR_W-1 to 0 silently.
- Bus-contention guard: any bus-loading strobe (j, call) asserted while co_n=0 is ignored. pc and stack are unchanged and stk_err is not set. ret and ce are unaffected by co_n.
- ce together with a higher-priority strobe: ce is dropped, with no extra increment.
- stk_err is sticky and clears only on clr_n.
- stk_full and stk_empty are combinational from sp.
- Reset mid-operation: stack contents are not cleared, only sp. Entries are undefined after reset and must not be read.

Decomposition:
- Shared header pc_defs.vh holds the priority-select encodings (OP_HOLD, OP_INC, OP_JMP, OP_JREL, OP_CALL, OP_RET) and the legal-range bounds for ADDR_W and STACK_DEPTH.
- Sub-module pc_return_stack (LIFO) provides:
  - parameters ADDR_W and STACK_DEPTH;
  - ports clk, clr_n, push, pop, din, dout, full, empty;
  - a register array, with sp of width $clog2(STACK_DEPTH+1);
  - push/pop qualified internally by full/empty.
- The top module owns the op decode, the PC register, the adder and the tri-state driver.

Test Plan:
- Count and wrap: ADDR_W=4, reset then ce=1 for 17 cycles -> pc_q runs 0..15, 0, 1. Bus stays 'z with co_n=1, and equals pc_q with co_n=0.
- Absolute and relative jump: pc=5, bus=0xA, j=1 -> pc=10. Then bus=4'b1110, j=1, rel=1 -> pc=8. Then ce=1 with j=1, bus=3 -> pc=3, with no extra increment.
- Call/return nesting: STACK_DEPTH=2, pc=2:
  - call bus=8 -> pc=8, empty=0;
  - call bus=12 -> pc=12, full=1;
  - ret -> pc=8;
  - ret -> pc=2, empty=1;
  - stk_err stays 0 throughout.
- Overflow/underflow: on a full stack, call bus=1 -> pc unchanged, stk_err=1. After clr_n pulse, stk_err=0 and pc=0. Then ret on an empty stack -> pc=0, stk_err=1.
- Contention and async reset:
  - co_n=0 with j=1, bus forced -> pc unchanged, stk_err=0.
  - clr_n asserted mid-cycle between edges -> pc_q=0 and stk_empty=1 immediately, without waiting for a clock edge.
- Priority: ret and call asserted together on a non-empty stack -> ret wins, pc = popped value, with no push.
